// File: rtl/resp_sig_analyzer.sv
// resp_sig_analyzer: Galois MISR response compactor with golden-signature pass/fail after NUM_VEC samples
module resp_sig_analyzer #(
   parameter int NUM_VEC = 32,
   parameter int RESP_W = 1,
   parameter int SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY = 16'h1021,
   parameter logic [SIG_W-1:0] SEED = '1,
   parameter logic [SIG_W-1:0] GOLDEN = 16'h0000,
   parameter int CNT_W = $clog2(NUM_VEC+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              resp_valid,
   input  logic [RESP_W-1:0] resp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  vec_cnt,
   output logic [SIG_W-1:0]  signature
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [SIG_W-1:0] sig_sh, sig_upd, sig_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic pass_nx, accept, last;
   assign sig_sh  = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0);
   assign sig_upd = sig_sh ^ SIG_W'(resp);
   assign accept  = (state == RUN) && resp_valid;
   assign last    = accept && (vec_cnt == CNT_W'(NUM_VEC-1));
   assign busy    = state == RUN;
   assign done    = state == DONE;
   always_comb begin
      state_nx = state;
      sig_nx = signature;
      cnt_nx = vec_cnt;
      pass_nx = pass;
      if (start && state != RUN) begin
         state_nx = RUN;
         sig_nx = SEED;
         cnt_nx = '0;
         pass_nx = 1'b0;
      end else if (accept) begin
         state_nx = last ? DONE : RUN;
         sig_nx = sig_upd;
         cnt_nx = vec_cnt + CNT_W'(1);
         pass_nx = last ? (sig_upd == GOLDEN) : pass;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         signature <= '0;
         vec_cnt <= '0;
         pass <= 1'b0;
      end else begin
         state <= state_nx;
         signature <= sig_nx;
         vec_cnt <= cnt_nx;
         pass <= pass_nx;
      end
   end
endmodule
